// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared sizes, FSM state encoding and score type for the argmax classifier
package argmax_pkg;
   localparam int N_CLASSES = 10;
   localparam int DATA_W    = 26;
   localparam int IDX_W     = 4;

   typedef enum logic [1:0] {IDLE, COLLECT, SCAN, DONE} state_t;
   typedef logic signed [DATA_W-1:0] score_t;
endpackage

// File: rtl/argmax_classifier_if.sv
// rtl/argmax_classifier_if.sv - neuron-sum input / classification output bundle
// Max_Score exists only when ARGMAX_SCORE_OUT_EN is defined.
interface argmax_classifier_if;
   logic                                                   Start;
   logic [argmax_pkg::N_CLASSES-1:0]                       Neuron_Valid;
   logic [argmax_pkg::N_CLASSES*argmax_pkg::DATA_W-1:0]    Neuron_Result;
   logic [argmax_pkg::IDX_W-1:0]                           Class_Out;
   logic                                                   Class_Valid;
   logic                                                   Busy;
   logic                                                   Error;
`ifdef ARGMAX_SCORE_OUT_EN
   logic [argmax_pkg::DATA_W-1:0]                          Max_Score;

   modport master (output Start, Neuron_Valid, Neuron_Result,
                   input  Class_Out, Class_Valid, Busy, Error, Max_Score);
   modport slave  (input  Start, Neuron_Valid, Neuron_Result,
                   output Class_Out, Class_Valid, Busy, Error, Max_Score);
`else
   modport master (output Start, Neuron_Valid, Neuron_Result,
                   input  Class_Out, Class_Valid, Busy, Error);
   modport slave  (input  Start, Neuron_Valid, Neuron_Result,
                   output Class_Out, Class_Valid, Busy, Error);
`endif
endinterface

// File: rtl/argmax_score_buf.sv
// rtl/argmax_score_buf.sv - per-class score registers, received mask and duplicate detect
module argmax_score_buf
   import argmax_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          capture,
   input  logic [N_CLASSES-1:0]          valid,
   input  logic [N_CLASSES*DATA_W-1:0]   result,
   input  logic [IDX_W-1:0]              rd_idx,
   output score_t                        rd_data,
   output logic                          all_recv,
   output logic                          dup
);
   score_t               score [N_CLASSES];
   logic [N_CLASSES-1:0] mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask <= '0;
         for (int k = 0; k < N_CLASSES; k++) score[k] <= '0;
      end else if (clear) begin
         mask <= '0;
      end else if (capture) begin
         mask <= mask | valid;
         for (int k = 0; k < N_CLASSES; k++)
            if (valid[k]) score[k] <= result[k*DATA_W +: DATA_W];
      end
   end

   assign all_recv = &mask;
   assign dup      = capture && |(valid & mask);

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < N_CLASSES) rd_data = score[rd_idx];
   end
endmodule

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - collects neuron sums, serially scans for the largest, reports its index
// Optional Max_Score output enabled by defining ARGMAX_SCORE_OUT_EN.
module argmax_classifier
   import argmax_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   argmax_classifier_if.slave bus
);
   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] best_idx;
   score_t           best;
   score_t           rd_data;
   logic             all_recv;
   logic             dup;
   logic             capture;
   logic [IDX_W-1:0] class_out;
   logic             class_valid;
   logic             busy;
   logic             error;

   // Start wins over a simultaneous valid, so that valid is neither stored nor flagged.
   assign capture = (state == COLLECT) && !bus.Start;

   argmax_score_buf u_buf (
      .clk      (clk),
      .rst      (rst),
      .clear    (bus.Start),
      .capture  (capture),
      .valid    (bus.Neuron_Valid),
      .result   (bus.Neuron_Result),
      .rd_idx   (idx),
      .rd_data  (rd_data),
      .all_recv (all_recv),
      .dup      (dup)
   );

`ifdef ARGMAX_SCORE_OUT_EN
   score_t max_score;
   assign bus.Max_Score = max_score;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         best_idx    <= '0;
         best        <= '0;
         class_out   <= '0;
         class_valid <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
         max_score   <= '0;
`endif
      end else begin
         class_valid <= 1'b0;
         if (bus.Start) begin
            state <= COLLECT;
            busy  <= 1'b1;
            error <= 1'b0;
            idx   <= '0;
         end else begin
            if (|bus.Neuron_Valid && (state != COLLECT || dup)) error <= 1'b1;
            case (state)
               IDLE: ;
               COLLECT: if (all_recv) begin
                  // idx is 0 throughout COLLECT, so rd_data is score[0] here.
                  state    <= SCAN;
                  best     <= rd_data;
                  best_idx <= '0;
                  idx      <= IDX_W'(1);
               end
               SCAN: begin
                  if (rd_data > best) begin
                     best     <= rd_data;
                     best_idx <= idx;
                  end
                  if (idx == IDX_W'(N_CLASSES-1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               DONE: begin
                  class_out   <= best_idx;
                  class_valid <= 1'b1;
`ifdef ARGMAX_SCORE_OUT_EN
                  max_score   <= best;
`endif
                  state       <= IDLE;
                  idx         <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.Class_Out   = class_out;
   assign bus.Class_Valid = class_valid;
   assign bus.Busy        = busy;
   assign bus.Error       = error;
endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - scoreboard bench for argmax_classifier
module tb_argmax_classifier;
   import argmax_pkg::*;

   typedef struct {
      logic [IDX_W-1:0] idx;
      score_t           score;
      int               cyc;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   int     pulses = 0;
   int     last_cap = 0;
   score_t sc [N_CLASSES];
   exp_t   sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   argmax_classifier_if bus ();
   argmax_classifier dut (.clk(clk), .rst(rst), .bus(bus));

   always @(negedge clk) begin
      exp_t e;
      if (bus.Class_Valid === 1'b1) begin
         pulses++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse class=%0d expected no pulse", bus.Class_Out);
         end else begin
            e = sb.pop_front();
            if (bus.Class_Out !== e.idx || cyc != e.cyc) begin
               fails++;
               $display("FAIL class_result class=%0d cyc=%0d expected class=%0d cyc=%0d",
                        bus.Class_Out, cyc, e.idx, e.cyc);
            end
`ifdef ARGMAX_SCORE_OUT_EN
            tests++;
            if ($signed(bus.Max_Score) !== e.score) begin
               fails++;
               $display("FAIL max_score got=%0d expected=%0d", $signed(bus.Max_Score), e.score);
            end
`endif
         end
      end
   end

   task automatic push_exp(input int k, input score_t s);
      exp_t e;
      e.idx   = IDX_W'(k);
      e.score = s;
      e.cyc   = last_cap + N_CLASSES + 1;
      sb.push_back(e);
   endtask

   task automatic pulse_start();
      bus.Start = 1'b1;
      @(posedge clk); #1;
      bus.Start = 1'b0;
   endtask

   task automatic send_mask(input logic [N_CLASSES-1:0] m);
      bus.Neuron_Valid = m;
      for (int k = 0; k < N_CLASSES; k++) bus.Neuron_Result[k*DATA_W +: DATA_W] = sc[k];
      @(posedge clk); #1;
      last_cap = cyc;
      bus.Neuron_Valid = '0;
   endtask

   task automatic send_one(input int k, input score_t v);
      sc[k] = v;
      send_mask(N_CLASSES'(1) << k);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
      @(posedge clk); #1;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL timeout pending=%0d expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_flags(input string name, input logic busy_e, input logic err_e);
      tests++;
      if (bus.Busy !== busy_e || bus.Error !== err_e) begin
         fails++;
         $display("FAIL %s busy=%b error=%b expected busy=%b error=%b",
                  name, bus.Busy, bus.Error, busy_e, err_e);
      end
   endtask

   task automatic test_reset();
      tests++;
      if (bus.Class_Out !== '0 || bus.Class_Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Error !== 1'b0) begin
         fails++;
         $display("FAIL reset_state out=%0d valid=%b busy=%b err=%b expected all 0",
                  bus.Class_Out, bus.Class_Valid, bus.Busy, bus.Error);
      end
`ifdef ARGMAX_SCORE_OUT_EN
      tests++;
      if (bus.Max_Score !== '0) begin
         fails++;
         $display("FAIL reset_max_score got=%0d expected 0", bus.Max_Score);
      end
`endif
   endtask

   task automatic test_single_peak();
      sc = '{5, -3, 12, 7, 100, 0, -50, 99, 1, 2};
      pulse_start();
      check_flags("peak_busy", 1'b1, 1'b0);
      send_mask('1);
      push_exp(4, 100);
      wait_done();
      check_flags("peak_idle", 1'b0, 1'b0);
   endtask

   task automatic test_staggered();
      pulse_start();
      for (int k = N_CLASSES-1; k >= 0; k--)
         send_one(k, (k == 7) ? score_t'(26'h0001234) : score_t'(k*16 - 100));
      push_exp(7, 26'h0001234);
      wait_done();
      check_flags("stagger_idle", 1'b0, 1'b0);
   endtask

   task automatic test_tie_negative();
      for (int k = 0; k < N_CLASSES; k++) sc[k] = -8;
      sc[2] = -1;
      sc[6] = -1;
      pulse_start();
      send_mask('1);
      push_exp(2, -1);
      wait_done();
   endtask

   task automatic test_protocol_error();
      for (int k = 0; k < N_CLASSES; k++) sc[k] = 20;
      pulse_start();
      send_one(3, 10);
      check_flags("first_valid", 1'b1, 1'b0);
      send_one(3, 500);
      check_flags("dup_valid", 1'b1, 1'b1);
      send_mask(~N_CLASSES'(8));
      push_exp(3, 500);
      wait_done();
      check_flags("err_sticky_done", 1'b0, 1'b1);
      send_one(0, 77);
      repeat (15) @(posedge clk);
      #1;
      check_flags("idle_valid", 1'b0, 1'b1);
      pulse_start();
      check_flags("start_clears", 1'b1, 1'b0);
   endtask

   task automatic test_abort();
      int p0;
      p0 = pulses;
      for (int k = 0; k < N_CLASSES; k++) sc[k] = 1000 + k;
      pulse_start();
      send_mask(N_CLASSES'(5'h1F));
      pulse_start();
      for (int k = 0; k < N_CLASSES; k++) sc[k] = -k;
      sc[8] = 30;
      send_mask('1);
      push_exp(8, 30);
      wait_done();
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if (pulses - p0 != 1) begin
         fails++;
         $display("FAIL abort_pulses got=%0d expected 1", pulses - p0);
      end
      check_flags("abort_idle", 1'b0, 1'b0);
   endtask

   task automatic test_start_with_valid();
      for (int k = 0; k < N_CLASSES; k++) sc[k] = 900;
      for (int k = 0; k < N_CLASSES; k++) bus.Neuron_Result[k*DATA_W +: DATA_W] = sc[k];
      bus.Neuron_Valid = '1;
      pulse_start();
      bus.Neuron_Valid = '0;
      check_flags("start_valid", 1'b1, 1'b0);
      for (int k = 0; k < N_CLASSES; k++) sc[k] = k;
      send_mask('1);
      check_flags("after_drop", 1'b1, 1'b0);
      push_exp(9, 9);
      wait_done();
   endtask

   task automatic test_async_reset();
      int p0;
      for (int k = 0; k < N_CLASSES; k++) sc[k] = 3 * k;
      sc[1] = 400;
      pulse_start();
      send_mask('1);
      repeat (4) @(posedge clk);
      p0 = pulses;
      #2 rst = 1'b1;
      #1;
      tests++;
      if (bus.Busy !== 1'b0 || bus.Class_Valid !== 1'b0 || bus.Class_Out !== '0 || bus.Error !== 1'b0) begin
         fails++;
         $display("FAIL async_reset busy=%b valid=%b out=%0d err=%b expected all 0",
                  bus.Busy, bus.Class_Valid, bus.Class_Out, bus.Error);
      end
`ifdef ARGMAX_SCORE_OUT_EN
      tests++;
      if (bus.Max_Score !== '0) begin
         fails++;
         $display("FAIL async_reset_max_score got=%0d expected 0", bus.Max_Score);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      tests++;
      if (pulses != p0) begin
         fails++;
         $display("FAIL reset_no_pulse pulses=%0d expected 0", pulses - p0);
      end
   endtask

   initial begin
      rst               = 1'b1;
      bus.Start         = 1'b0;
      bus.Neuron_Valid  = '0;
      bus.Neuron_Result = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_single_peak();
      test_staggered();
      test_tie_negative();
      test_protocol_error();
      test_abort();
      test_start_with_valid();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Consumer end of the neuron-sum interface. Collects the N_CLASSES neuron sums, each delivered as a 26-bit result plus a one-cycle valid pulse.
- Once all sums are held, it scans them serially and reports the index of the largest sum as the classified digit, with a one-cycle valid pulse.
- Sits after the ten parallel neuron-sum blocks; it is the final stage of the hardware network.

Parameters:
- N_CLASSES, 10, number of neuron sums and output classes.
- DATA_W, 26, width of each neuron sum (two's-complement fixed point).
- IDX_W, 4, width of the class index; must satisfy 2**IDX_W >= N_CLASSES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse; clears collected state and arms collection for a new image.
- Neuron_Valid  in  N_CLASSES  bit k pulses for one cycle when sum k is presented.
- Neuron_Result  in  N_CLASSES*DATA_W  sum k occupies bits [k*DATA_W +: DATA_W].
- Class_Out  out  IDX_W  winning class index; held until the next Start.
- Class_Valid  out  1  one-cycle pulse when Class_Out is updated.
- Busy  out  1  high in COLLECT and SCAN.
- Error  out  1  sticky; set by a protocol violation, cleared by Start or rst.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: Class_Out=0, Class_Valid=0, Busy=0, Error=0, state=IDLE, received mask=0, all score registers=0.
- States and transitions:
  - IDLE: waits for Start.
  - COLLECT: on each edge, for every k with Neuron_Valid[k]=1, store score[k] and set mask[k]. Several bits may be set in the same cycle. When the mask becomes all ones, go to SCAN on the next edge.
  - SCAN: best_idx=0 and best=score[0] on entry. Compare one entry per cycle, idx=1..N_CLASSES-1. Replace the best only when score[idx] > best (signed), so ties keep the lower index.
  - DONE: lasts one cycle. Drive Class_Out=best_idx and Class_Valid=1, then return to IDLE.
- Latency: Class_Valid rises N_CLASSES+1 edges after the edge that captured the last missing sum (11 cycles for the defaults). This holds whether the sums arrive together or spread out.
- Comparison is signed DATA_W-bit; no extension or saturation is needed.
- Boundary conditions:
  - Neuron_Valid[k] with mask[k] already set (in COLLECT): overwrite score[k] and set Error.
  - Any Neuron_Valid bit high in IDLE, SCAN or DONE: data is ignored and Error is set.
  - Start in any state: clear the mask and Error, enter COLLECT on the next edge, and abort any scan without pulsing Class_Valid. Class_Out keeps its old value.
  - Start and Neuron_Valid in the same cycle: Start wins and the valid is dropped. Error is not set.
  - rst mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: ARGMAX_SCORE_OUT_EN.
- Defined: adds output Max_Score (DATA_W), equal to the winning sum. It updates on the same edge as Class_Out, is held until the next DONE, and resets to 0.
- Undefined: the port is absent and only the index is retained; the running-best register is still needed internally.

Decomposition:
- Package argmax_pkg holds:
  - N_CLASSES, DATA_W, IDX_W defaults;
  - the state enum (IDLE, COLLECT, SCAN, DONE);
  - a score_t typedef (signed DATA_W).
- One sub-module is natural: argmax_score_buf. It contains the N_CLASSES score registers, the received mask, the all-received flag and the duplicate-detect logic, and provides a read port indexed by scan idx.
- The top module contains the FSM, the scan comparator and the output registers.

Test Plan:
- Single peak: Start, then all ten valids in one cycle with scores 0..9 equal to {5,-3,12,7,100,0,-50,99,1,2} -> Class_Out=4, Class_Valid high exactly 11 cycles after the capture edge, Error=0.
- Staggered arrival: valids one per cycle in order 9..0, with score 7 the largest at 0x0001234 -> Class_Out=7, Class_Valid 11 cycles after the valid for class 0.
- Tie and negatives: all scores -8 except scores 2 and 6, both -1 -> Class_Out=2.
- Protocol errors: valid[3] pulsed twice (second value larger, and the winner), then the rest -> Error=1 and Class_Out=3. Then a valid while in IDLE -> Error stays 1; the next Start clears it.
- Abort: Start, five valids, Start again, then all ten valids -> exactly one Class_Valid pulse, reflecting only the second set.
- Async reset in SCAN: assert rst between clk edges -> Busy, Class_Valid and Class_Out go to 0 immediately with no pulse. With ARGMAX_SCORE_OUT_EN defined, Max_Score=0 after reset and equals the winning score after the single-peak test.
